// File: rtl/led_pattern_gen.sv
// Multi-channel status-LED pattern generator: OFF, solid ON, symmetric BLINK or
// Morse SOS per channel, all channels timed from one shared prescaler tick.
module led_pattern_gen #(
    parameter int CHANNELS    = 4,
    parameter int TICK_DIV    = 25000000,
    parameter int BLINK_UNITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*CHANNELS-1:0] mode,
    output logic [CHANNELS-1:0]   led,
    output logic [CHANNELS-1:0]   sos_frame
);

    localparam int PW   = $clog2(TICK_DIV);
    localparam int MAXU = (BLINK_UNITS > 7) ? BLINK_UNITS : 7;
    localparam int UW   = $clog2(MAXU + 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_SOS   = 2'b11
    } mode_e;

    // SOS steps alternate lit/dark starting lit, so lit == even step index
    function automatic logic [2:0] sos_units(input logic [4:0] s);
        case (s)
            5'd5, 5'd6, 5'd8, 5'd10, 5'd11: sos_units = 3'd3;
            5'd17:                          sos_units = 3'd7;
            default:                        sos_units = 3'd1;
        endcase
    endfunction

    logic [PW-1:0]       pre_q, pre_d;
    logic                tick;
    mode_e               mode_q [CHANNELS];
    mode_e               mode_d [CHANNELS];
    logic [4:0]          step_q [CHANNELS];
    logic [4:0]          step_d [CHANNELS];
    logic [UW-1:0]       unit_q [CHANNELS];
    logic [UW-1:0]       unit_d [CHANNELS];
    logic [CHANNELS-1:0] led_q, led_d;
    logic [CHANNELS-1:0] frame_q, frame_d;

    assign tick = (pre_q == PW'(TICK_DIV - 1));

    always_comb begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            mode_d[i]  = mode_e'(mode[2*i +: 2]);
            step_d[i]  = step_q[i];
            unit_d[i]  = unit_q[i];
            led_d[i]   = led_q[i];
            frame_d[i] = 1'b0;
            if (mode_d[i] != mode_q[i]) begin
                // restart wins over a coincident tick
                step_d[i] = '0;
                unit_d[i] = '0;
                led_d[i]  = (mode_d[i] != MODE_OFF);
            end else begin
                case (mode_q[i])
                    MODE_OFF: begin
                        step_d[i] = '0;
                        unit_d[i] = '0;
                        led_d[i]  = 1'b0;
                    end
                    MODE_ON: begin
                        step_d[i] = '0;
                        unit_d[i] = '0;
                        led_d[i]  = 1'b1;
                    end
                    MODE_BLINK: begin
                        if (tick) begin
                            if (unit_q[i] == UW'(BLINK_UNITS - 1)) begin
                                unit_d[i] = '0;
                                step_d[i] = {4'b0000, ~step_q[i][0]};
                                led_d[i]  = step_q[i][0];
                            end else begin
                                unit_d[i] = unit_q[i] + 1'b1;
                            end
                        end
                    end
                    MODE_SOS: begin
                        if (tick) begin
                            if (unit_q[i] == UW'(sos_units(step_q[i]) - 3'd1)) begin
                                unit_d[i] = '0;
                                if (step_q[i] == 5'd17) begin
                                    step_d[i]  = '0;
                                    led_d[i]   = 1'b1;
                                    frame_d[i] = 1'b1;
                                end else begin
                                    step_d[i] = step_q[i] + 5'd1;
                                    led_d[i]  = step_q[i][0];
                                end
                            end else begin
                                unit_d[i] = unit_q[i] + 1'b1;
                            end
                        end
                    end
                    default: begin
                        led_d[i] = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q   <= '0;
            led_q   <= '0;
            frame_q <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                mode_q[i] <= MODE_OFF;
                step_q[i] <= '0;
                unit_q[i] <= '0;
            end
        end else begin
            pre_q   <= pre_d;
            led_q   <= led_d;
            frame_q <= frame_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                mode_q[i] <= mode_d[i];
                step_q[i] <= step_d[i];
                unit_q[i] <= unit_d[i];
            end
        end
    end

    assign led       = led_q;
    assign sos_frame = frame_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench: stimulus queues expected LED edges and frame pulses with
// hand-computed cycle stamps; a monitor pops and compares each observed event.
module tb_led_pattern_gen;

    localparam int EV_FALL  = 0;
    localparam int EV_RISE  = 1;
    localparam int EV_FRAME = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] mode = '0;
    logic [1:0] led;
    logic [1:0] sos_frame;
    logic [1:0] prev_led = '0;

    int cyc;
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];

    // cumulative units at the end of each SOS step (one unit = 4 clk here)
    int sos_cum [18] = '{1, 2, 3, 4, 5, 8, 11, 12, 15, 16, 19, 22, 23, 24, 25, 26, 27, 34};

    led_pattern_gen #(
        .CHANNELS   (2),
        .TICK_DIV   (4),
        .BLINK_UNITS(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .led      (led),
        .sos_frame(sos_frame)
    );

    always #5 clk = ~clk;

    // cycle stamp: number of clk edges since reset release; ticks land on multiples of 4
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic push_ev(input int ch, input int kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        if (ch == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    task automatic push_sos(input int ch, input int b, input int nsteps);
        for (int k = 0; k < nsteps; k++) begin
            push_ev(ch, (k % 2 == 0) ? EV_FALL : EV_RISE, b + 4 * sos_cum[k]);
            if (k == 17) push_ev(ch, EV_FRAME, b + 4 * sos_cum[k]);
        end
    endtask

    task automatic observe(input int ch, input int kind);
        ev_t e;
        int  sz;
        n_checks++;
        sz = (ch == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
            $display("FAIL event_ch%0d: got kind %0d at cyc %0d, expected no event", ch, kind, cyc);
        end else begin
            if (ch == 0) e = q0.pop_front();
            else         e = q1.pop_front();
            if (e.kind == kind && e.cyc == cyc) n_pass++;
            else $display("FAIL event_ch%0d: got kind %0d at cyc %0d, expected kind %0d at cyc %0d",
                          ch, kind, cyc, e.kind, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_led = '0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (led[ch] != prev_led[ch]) observe(ch, led[ch] ? EV_RISE : EV_FALL);
                if (sos_frame[ch]) observe(ch, EV_FRAME);
            end
            prev_led = led;
        end
    end

    task automatic wait_cyc(input int c);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cyc != c && n < 2000);
        if (cyc != c) check("wait_timeout", cyc, c);
    endtask

    task automatic check_empty(input string name);
        check({name, "_q0_left"}, q0.size(), 0);
        check({name, "_q1_left"}, q1.size(), 0);
    endtask

    initial begin
        #12;
        check("rst_led", led, 0);
        check("rst_frame", sos_frame, 0);
        @(negedge clk);
        rst = 1'b0;

        // static ON/OFF
        wait_cyc(2);
        mode = 4'b0001;
        push_ev(0, EV_RISE, 3);
        wait_cyc(4);
        check("on_led", led, 1);
        wait_cyc(203);
        check("on_hold_led", led, 1);
        check_empty("static");
        mode = 4'b0000;
        push_ev(0, EV_FALL, 204);

        // BLINK restart one clk after a tick: 7 clk first lit phase, then 8/8
        wait_cyc(208);
        mode = 4'b0010;
        push_ev(0, EV_RISE, 209);
        push_ev(0, EV_FALL, 216);
        for (int p = 0; p < 5; p++) begin
            push_ev(0, EV_RISE, 224 + 16 * p);
            push_ev(0, EV_FALL, 232 + 16 * p);
        end
        push_ev(0, EV_RISE, 304);
        wait_cyc(306);
        mode = 4'b0000;
        push_ev(0, EV_FALL, 307);

        // SOS on ch1, three full frames then switch to BLINK inside the step-8 dash
        wait_cyc(308);
        mode = 4'b1100;
        push_ev(1, EV_RISE, 309);
        push_sos(1, 308, 18);
        push_sos(1, 444, 18);
        push_sos(1, 580, 18);
        push_sos(1, 716, 8);
        wait_cyc(764);
        mode = 4'b1000;
        push_ev(1, EV_FALL, 772);
        push_ev(1, EV_RISE, 780);
        push_ev(1, EV_FALL, 788);
        push_ev(1, EV_RISE, 796);
        push_ev(1, EV_FALL, 804);
        push_ev(1, EV_RISE, 812);
        wait_cyc(765);
        check("sos2blink_led", led[1], 1);
        wait_cyc(814);
        mode = 4'b0000;
        push_ev(1, EV_FALL, 815);
        wait_cyc(818);
        check_empty("blink_switch");

        // both channels to SOS together, then restart ch0 on a tick edge
        wait_cyc(820);
        mode = 4'b1111;
        push_ev(0, EV_RISE, 821);
        push_ev(1, EV_RISE, 821);
        push_sos(0, 820, 4);
        push_sos(1, 820, 18);
        push_sos(1, 956, 18);
        push_sos(1, 1092, 12);
        wait_cyc(839);
        mode = 4'b1110;
        push_ev(0, EV_FALL, 848);
        push_ev(0, EV_RISE, 856);
        push_ev(0, EV_FALL, 864);
        wait_cyc(866);
        mode = 4'b1100;

        // async reset during SOS step 12 of ch1
        wait_cyc(1181);
        check("pre_rst_led", led, 2);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_led", led, 0);
        check("async_rst_frame", sos_frame, 0);
        check_empty("pre_reset");
        push_ev(1, EV_RISE, 1);
        push_sos(1, 0, 18);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_cyc(138);
        check_empty("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Multi-channel status-LED pattern generator for the elevator panel and its alarm indicators.
- Each channel independently shows OFF, solid ON, a symmetric blink, or a true Morse "SOS" pattern (... --- ...).
- All channels are timed from one shared prescaler.
- Mode inputs are driven by the elevator FSM; outputs drive board LEDs directly.

Parameters:
- CHANNELS, 4, number of independent LED channels (1..16).
- TICK_DIV, 25000000, clk cycles per timing unit (250 ms at 100 MHz); must be >= 2.
- BLINK_UNITS, 4, on-time and off-time of BLINK mode, in units (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- mode  in  2*CHANNELS  per-channel mode; channel i uses bits [2i+1:2i]. Encoding: 00 OFF, 01 ON, 10 BLINK, 11 SOS.
- led  out  CHANNELS  registered LED drive, 1 = lit.
- sos_frame  out  CHANNELS  one-clk pulse when channel i completes a full SOS frame.

Behaviour:
- Reset (async, immediate):
  - led = 0, sos_frame = 0, prescaler = 0.
  - All per-channel step and unit counters = 0.
  - All registered modes (mode_q) = 00.
- Prescaler:
  - Free-running counter 0..TICK_DIV-1; wraps to 0.
  - tick = 1 for the single cycle in which the count equals TICK_DIV-1.
  - Shared by all channels and never reset by mode changes.
- Per-channel mode tracking:
  - mode_q[i] <= mode[i] every clk.
  - restart[i] = (mode[i] != mode_q[i]). Because mode_q resets to OFF, a nonzero mode held through reset release causes a restart on the first clk.
  - On a restart edge: step <= 0, unit_cnt <= 0, sos_frame <= 0, and led <= first value of the new mode (OFF:0, ON:1, BLINK:1, SOS:1).
  - Latency from mode change to led is exactly 1 clk.
  - A restart has priority over a simultaneous tick; that tick is ignored for this channel.
- OFF / ON:
  - led held at 0 / 1.
  - Counters are held at 0.
- BLINK:
  - Two phases, step 0 = lit and step 1 = dark, each BLINK_UNITS units long.
  - On each tick, unit_cnt increments. When unit_cnt == len-1 on a tick: unit_cnt <= 0, step toggles, led <= new phase value.
- SOS, 18 steps (0..17) from a fixed constant table, as (lit, units):
  - S: (1,1)(0,1)(1,1)(0,1)(1,1)(0,3)
  - O: (1,3)(0,1)(1,3)(0,1)(1,3)(0,3)
  - S: (1,1)(0,1)(1,1)(0,1)(1,1)(0,7)
  - Frame length is 34 units.
  - Advance rule is the same as BLINK. After step 17, step wraps to 0 and led <= 1.
  - sos_frame[i] = 1 for exactly the clk after the tick that ends step 17; 0 otherwise.
- Phase alignment:
  - The first unit after a restart ends at the next shared tick, so it may be 1..TICK_DIV cycles long.
  - All later units are exactly TICK_DIV cycles.
- Channels are fully independent. Simultaneous changes on several channels are each handled in the same cycle.
- Widths:
  - unit_cnt is wide enough for max(7, BLINK_UNITS).
  - step is 5 bits.
  - No counter may overflow or wrap outside the rules above.
- Mode change mid-step (e.g. SOS to BLINK at step 9): restart rule applies; no residue of the old pattern remains.
- Reset asserted mid-frame: all outputs go to 0 immediately and asynchronously. After release, behaviour is identical to power-up.

Test Plan:
(All scenarios use CHANNELS=2, TICK_DIV=4, BLINK_UNITS=2.)
- Reset/static: assert rst, mode=0x0, release, then set ch0=ON, ch1=OFF -> led=2'b00 during reset, sos_frame=0; one clk after the change led[0]=1, led[1]=0, held for 200 clk.
- BLINK: ch0=BLINK, aligned so the change lands one clk after a tick -> led[0] lit 1 clk later. After the first (shortened) unit, steady state is 8 clk lit, 8 clk dark, period 16 clk, checked over 5 periods.
- SOS: ch1=SOS -> led[1] on-time sequence in cycles after the first unit is 4,4,4 / 12,12,12 / 4,4,4. Gaps are 4 within a letter, 12 between letters, 28 at frame end. Frame period is 136 clk; sos_frame[1] pulses once per frame, one clk wide, exactly 136 clk apart.
- Mode change mid-pattern: switch ch1 SOS→BLINK during the dash at step 8 -> led[1]=1 on the next clk, then BLINK timing; no sos_frame pulse. Switch BLINK→OFF -> led[1]=0 on the next clk.
- Independence/simultaneity: ch0 and ch1 both change to SOS on the same clk -> identical led waveforms. Later, a change on ch0 coinciding with a tick restarts only ch0; ch1 timing is unaffected.
- Reset mid-operation: assert rst asynchronously (between clk edges) at step 12 of SOS -> led and sos_frame go to 0 without a clk edge. After release with mode held at SOS, led=1 on the first clk and the frame restarts from step 0.
